s8sp_controller: RTL
====================

// Module: s8sp_controller
// PURPOSE
//  Fetch/decode/execute sequencer for the S8SP 8-bit datapath (data_block). Drives every datapath strobe from ir_code.
//  Runs the external memory read/write handshake and guarantees a single driver each on data_bus and addr_bus.
//  Sits beside data_block in the S8SP top level, one clock domain.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ack per memory access before bus error (1..255)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  reset          in   1  synchronous, active-high reset
//  ir_code        in   8  current IR from data_block; [7:4]=opcode, [3:0]=unused
//  mem_ack        in   1  memory done: read data valid on data_bus / write taken, this cycle
//  mem_rd         out  1  memory read request, held until mem_ack
//  mem_wr         out  1  memory write request, held until mem_ack
//  load_ar, ar_on_addr, ar_2_data, load_dr, dr_2_data   out 1 each  datapath strobes
//  load_lsb_gr, load_msb_gr, gr_2_data                  out 1 each  datapath strobes
//  load_ar_2_pr, inc_pr, pr_2_data, pr_on_addr          out 1 each  datapath strobes
//  load_ir, ir_2_data, alu_2_data, flag_2_data, sub_nadd out 1 each datapath strobes
//  add_oprnd1_sel out  2  ALU operand 1 select (00 AR, 01 DR, 10 GR, 11 PR)
//  add_oprnd2_sel out  2  ALU operand 2 select, same encoding
//  halted         out  1  high in HALT state
//  bus_err        out  1  sticky, set on memory timeout, cleared by reset only
//  illegal_op     out  1  one-cycle pulse in DECODE for an undefined opcode
// BEHAVIOUR
//  Reset: state=START, timeout counter=0, bus_err=0. All outputs decode from state and are 0 in START.
//  Outputs are combinational from (state, ir_code, mem_ack). Exactly one of the *_2_data strobes is high at a time, or none.
//  Same rule for ar_on_addr/pr_on_addr.
//  States: START -> FETCH unconditionally (1 cycle).
//   FETCH : pr_on_addr, mem_rd. On mem_ack: load_ir, inc_pr, -> DECODE.
//   DECODE: ir_code valid. Single-cycle ops execute here, then -> FETCH.
//           LDA/STA/JMP -> OPND. HLT -> HALT.
//   OPND  : pr_on_addr, mem_rd. On mem_ack, LDA/STA: load_ar, inc_pr, -> MEM. JMP: load_ar_2_pr only (no inc_pr), -> FETCH.
//   MEM   : ar_on_addr. LDA: mem_rd; on ack load_dr. STA: mem_wr + gr_2_data held for the whole state. On ack -> FETCH.
//   HALT  : halted=1, all strobes 0. Exit only via reset.
//  Opcodes executed in DECODE (GR write = load_lsb_gr & load_msb_gr together):
//   0x0 NOP: no strobes.  0x1 LDL: ir_2_data+load_lsb_gr.  0x2 LDH: ir_2_data+load_msb_gr.
//   0x5 ADD: sel1=10, sel2=01, sub_nadd=0, alu_2_data, GR write.  0x6 SUB: same with sub_nadd=1.
//   0x7 MOV: gr_2_data+load_dr.  0x8 GFL: flag_2_data+GR write.
//  Multi-cycle opcodes: 0x3 LDA, 0x4 STA, 0x9 JMP, each with a one-byte address operand. 0xF is HLT.
//  Undefined 0xA-0xE: illegal_op pulse, executed as NOP.
//  sel/sub_nadd default 00/00/0 outside ADD/SUB.
//  Memory wait: counter clears on entry to FETCH/OPND/MEM and increments each cycle with mem_rd|mem_wr high and mem_ack low.
//   When the counter reaches MEM_TIMEOUT with no ack: set bus_err, -> HALT; no load strobe issued.
//   mem_ack in the same cycle the counter hits the limit counts as success.
//  mem_ack is ignored in START, DECODE and HALT.
//  Reset in any state (mid-access included) -> START next edge; mem_rd/mem_wr drop in the reset cycle.
//  Latency with zero-wait memory (ack in first cycle): single-cycle op = 2 cycles, LDA/STA = 4, JMP = 3.
// TESTING
//  Reset, ack tied 1, memory NOP,NOP -> START 1 cycle, then FETCH/DECODE alternate; inc_pr once per 2 cycles; illegal_op=0.
//  LDL 0x15, LDH 0x23, ADD, zero wait -> ALU sel 10/01, sub_nadd=0, GR loaded in DECODE; no two *_2_data ever high together.
//  LDA 0x30,0x80, ack delayed 3 cycles on each access -> mem_rd held 4 cycles per access; load_ar then load_dr fire on ack cycle; total 2+4*3=14 cycles.
//  STA 0x40,0x55 -> MEM state: ar_on_addr, mem_wr, gr_2_data all high until ack; pr_on_addr low there.
//  JMP 0x90,0x20 -> load_ar_2_pr on operand ack, no inc_pr that cycle, next FETCH uses new PR.
//  Never ack in FETCH, MEM_TIMEOUT=15 -> bus_err=1 and halted=1 after 15 wait cycles; reset mid-wait clears both and returns to START.

Source files
------------

// File: rtl/s8sp_controller_if.sv
// S8SP external memory handshake bundle.
// The controller is master; the memory model/port is slave.
interface s8sp_controller_if;
  logic mem_rd;
  logic mem_wr;
  logic mem_ack;

  modport master (
    output mem_rd,
    output mem_wr,
    input  mem_ack
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    output mem_ack
  );
endinterface

// File: rtl/s8sp_controller.sv
// S8SP fetch/decode/execute sequencer.
// All datapath strobes decode from state, ir_code and mem_ack.
module s8sp_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir_code,
  s8sp_controller_if.master mem,
  output logic       load_ar,
  output logic       ar_on_addr,
  output logic       ar_2_data,
  output logic       load_dr,
  output logic       dr_2_data,
  output logic       load_lsb_gr,
  output logic       load_msb_gr,
  output logic       gr_2_data,
  output logic       load_ar_2_pr,
  output logic       inc_pr,
  output logic       pr_2_data,
  output logic       pr_on_addr,
  output logic       load_ir,
  output logic       ir_2_data,
  output logic       alu_2_data,
  output logic       flag_2_data,
  output logic       sub_nadd,
  output logic [1:0] add_oprnd1_sel,
  output logic [1:0] add_oprnd2_sel,
  output logic       halted,
  output logic       bus_err,
  output logic       illegal_op
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDL = 4'h1;
  localparam logic [3:0] OP_LDH = 4'h2;
  localparam logic [3:0] OP_LDA = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_GFL = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_MEM,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic          rd, wr;
  logic          ack;
  logic          last_wait;
  logic [3:0]    op;
  logic          ir_unused;

  assign op        = ir_code[7:4];
  assign ir_unused = ^ir_code[3:0];
  assign ack       = mem.mem_ack;
  // last cycle an ack is still accepted; without it the access times out
  assign last_wait = (cnt_q == CW'(MEM_TIMEOUT - 1));

  assign mem.mem_rd = rd & ~reset;
  assign mem.mem_wr = wr & ~reset;
  assign bus_err    = berr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_START;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    berr_d         = berr_q;
    rd             = 1'b0;
    wr             = 1'b0;
    load_ar        = 1'b0;
    ar_on_addr     = 1'b0;
    ar_2_data      = 1'b0;
    load_dr        = 1'b0;
    dr_2_data      = 1'b0;
    load_lsb_gr    = 1'b0;
    load_msb_gr    = 1'b0;
    gr_2_data      = 1'b0;
    load_ar_2_pr   = 1'b0;
    inc_pr         = 1'b0;
    pr_2_data      = 1'b0;
    pr_on_addr     = 1'b0;
    load_ir        = 1'b0;
    ir_2_data      = 1'b0;
    alu_2_data     = 1'b0;
    flag_2_data    = 1'b0;
    sub_nadd       = 1'b0;
    add_oprnd1_sel = 2'b00;
    add_oprnd2_sel = 2'b00;
    halted         = 1'b0;
    illegal_op     = 1'b0;

    unique case (state_q)
      S_START: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        pr_on_addr = 1'b1;
        rd         = 1'b1;
        if (ack) begin
          load_ir = 1'b1;
          inc_pr  = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (last_wait) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        cnt_d   = '0;
        state_d = S_FETCH;
        unique case (op)
          OP_NOP: ;
          OP_LDL: begin
            ir_2_data   = 1'b1;
            load_lsb_gr = 1'b1;
          end
          OP_LDH: begin
            ir_2_data   = 1'b1;
            load_msb_gr = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            add_oprnd1_sel = 2'b10;
            add_oprnd2_sel = 2'b01;
            sub_nadd       = (op == OP_SUB);
            alu_2_data     = 1'b1;
            load_lsb_gr    = 1'b1;
            load_msb_gr    = 1'b1;
          end
          OP_MOV: begin
            gr_2_data = 1'b1;
            load_dr   = 1'b1;
          end
          OP_GFL: begin
            flag_2_data = 1'b1;
            load_lsb_gr = 1'b1;
            load_msb_gr = 1'b1;
          end
          OP_LDA, OP_STA, OP_JMP: state_d = S_OPND;
          OP_HLT: state_d = S_HALT;
          default: illegal_op = 1'b1;
        endcase
      end
      S_OPND: begin
        pr_on_addr = 1'b1;
        rd         = 1'b1;
        if (ack) begin
          cnt_d = '0;
          if (op == OP_JMP) begin
            load_ar_2_pr = 1'b1;
            state_d      = S_FETCH;
          end else begin
            load_ar = 1'b1;
            inc_pr  = 1'b1;
            state_d = S_MEM;
          end
        end else if (last_wait) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEM: begin
        ar_on_addr = 1'b1;
        if (op == OP_STA) begin
          wr        = 1'b1;
          gr_2_data = 1'b1;
        end else begin
          rd = 1'b1;
        end
        if (ack) begin
          load_dr = (op != OP_STA);
          cnt_d   = '0;
          state_d = S_FETCH;
        end else if (last_wait) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_START;
    endcase
  end

endmodule
